// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;
  localparam logic [2:0] OP_LOAD  = 3'b101;
  localparam logic [2:0] OP_STORE = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // ALU op codes match the low opcode bits; PASS forwards the address/data path.
  localparam logic [2:0] ALU_PASS = 3'b000;

endpackage

// File: rtl/ctrl_opcode_decoder.sv
// Combinational opcode classifier. Flags are mutually exclusive; any nonzero
// bit above [2:0] makes the opcode illegal and suppresses every other flag.
module ctrl_opcode_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic                is_nop_o,
  output logic                is_alu_o,
  output logic                is_load_o,
  output logic                is_store_o,
  output logic                is_halt_o,
  output logic                is_illegal_o
);

  logic       upper_nz;
  logic [2:0] base;

  generate
    if (OPCODE_W > 3) begin : g_wide
      assign upper_nz = |opcode_i[OPCODE_W-1:3];
    end else begin : g_narrow
      assign upper_nz = 1'b0;
    end
  endgenerate

  assign base = opcode_i[2:0];

  // Classify the opcode; legal classes only when the upper bits are clear
  always_comb begin
    is_nop_o     = 1'b0;
    is_alu_o     = 1'b0;
    is_load_o    = 1'b0;
    is_store_o   = 1'b0;
    is_halt_o    = 1'b0;
    is_illegal_o = upper_nz;
    if (!upper_nz) begin
      case (base)
        OP_NOP:                     is_nop_o   = 1'b1;
        OP_ADD, OP_SUB,
        OP_AND, OP_OR:              is_alu_o   = 1'b1;
        OP_LOAD:                    is_load_o  = 1'b1;
        OP_STORE:                   is_store_o = 1'b1;
        OP_HALT:                    is_halt_o  = 1'b1;
        default:                    is_nop_o   = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM for the 8-bit CPU: sequences fetch, decode, execute,
// memory and writeback, with memory timeout and illegal-opcode detection.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | parked, waiting for En
//  FETCH  | Instr_ready high, waiting for Instr_valid (En=0 parks)
//  DECODE | classify latched opcode; NOP/illegal retire here
//  EXEC   | ALU op driven for one cycle
//  MEM    | Mem_req held until Mem_ready or timeout; STORE retires here
//  WB     | register write strobe; ALU/LOAD retire here
//  HALT   | terminal until Reset (HALT opcode or memory timeout)
module multicycle_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 3,
  parameter int unsigned ALU_OP_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                En,
  input  logic                Instr_valid,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                Mem_ready,
  output logic                Instr_ready,
  output logic                Mem_req,
  output logic                En_write_reg,
  output logic                En_write_mem,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                Pc_inc,
  output logic                Busy,
  output logic                Halted,
  output logic                Err_illegal,
  output logic                Err_timeout,
  output logic [CNT_W-1:0]    Instr_count
);

  localparam int unsigned      TO_W    = $clog2(MEM_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t              state_q,  state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [TO_W-1:0]     tcnt_q,   tcnt_d;
  logic [CNT_W-1:0]    icnt_q,   icnt_d;
  logic                err_to_q, err_to_d;

  logic is_nop, is_alu, is_load, is_store, is_halt, is_illegal;
  logic retire;

  ctrl_opcode_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_dec (
    .opcode_i     (opcode_q),
    .is_nop_o     (is_nop),
    .is_alu_o     (is_alu),
    .is_load_o    (is_load),
    .is_store_o   (is_store),
    .is_halt_o    (is_halt),
    .is_illegal_o (is_illegal)
  );

  // State, latched opcode, timeout counter, retire counter and sticky error
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      tcnt_q   <= '0;
      icnt_q   <= '0;
      err_to_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      tcnt_q   <= tcnt_d;
      icnt_q   <= icnt_d;
      err_to_q <= err_to_d;
    end
  end

  // Next-state logic, opcode capture and memory timeout tracking
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    tcnt_d   = tcnt_q;
    err_to_d = err_to_q;
    case (state_q)
      ST_IDLE: begin
        if (En) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (!En) begin
          state_d = ST_IDLE;
        end else if (Instr_valid) begin
          opcode_d = Opcode;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (is_alu) begin
          state_d = ST_EXEC;
        end else if (is_load || is_store) begin
          state_d = ST_MEM;
          tcnt_d  = '0;
        end else if (is_halt) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: state_d = ST_WB;
      ST_MEM: begin
        // A ready on the final allowed cycle takes precedence over the timeout.
        if (Mem_ready) begin
          state_d = is_store ? ST_FETCH : ST_WB;
        end else if (tcnt_q == TO_LAST) begin
          err_to_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // Retire detection and the saturating retired-instruction counter.
  // A STORE retires on the cycle memory acknowledges, so Pc_inc in MEM is
  // the one output qualified by an input (Mem_ready).
  always_comb begin
    retire = 1'b0;
    case (state_q)
      ST_DECODE: retire = is_nop || is_illegal;
      ST_MEM:    retire = is_store && Mem_ready;
      ST_WB:     retire = 1'b1;
      default:   retire = 1'b0;
    endcase
    icnt_d = icnt_q;
    if (retire && (icnt_q != '1)) icnt_d = icnt_q + 1'b1;
  end

  // Output decode from registered state and latched opcode
  always_comb begin
    Instr_ready  = 1'b0;
    Mem_req      = 1'b0;
    En_write_reg = 1'b0;
    En_write_mem = 1'b0;
    ALU_OP       = ALU_OP_W'(ALU_PASS);
    Busy         = 1'b1;
    Halted       = 1'b0;
    Err_illegal  = 1'b0;
    case (state_q)
      ST_IDLE:   Busy = 1'b0;
      ST_FETCH:  Instr_ready = 1'b1;
      ST_DECODE: Err_illegal = is_illegal;
      ST_EXEC:   ALU_OP = ALU_OP_W'(opcode_q[2:0]);
      ST_MEM: begin
        Mem_req      = 1'b1;
        En_write_mem = is_store;
      end
      ST_WB: begin
        En_write_reg = 1'b1;
        if (is_alu) ALU_OP = ALU_OP_W'(opcode_q[2:0]);
      end
      ST_HALT: begin
        Busy   = 1'b0;
        Halted = 1'b1;
      end
      default: Busy = 1'b0;
    endcase
    Pc_inc      = retire;
    Err_timeout = err_to_q;
    Instr_count = icnt_q;
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit: a 4-bit-opcode instance for the
// main scenarios and a 2-bit-counter instance for saturation.
module tb_multicycle_control_unit;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        En, Instr_valid, Mem_ready;
  logic [3:0]  Opcode;
  logic        Instr_ready, Mem_req, En_write_reg, En_write_mem;
  logic [2:0]  ALU_OP;
  logic        Pc_inc, Busy, Halted, Err_illegal, Err_timeout;
  logic [15:0] Instr_count;

  logic        s_en, s_valid, s_mem_ready;
  logic [2:0]  s_opcode;
  logic        s_ready, s_mem_req, s_wreg, s_wmem;
  logic [2:0]  s_alu_op;
  logic        s_pc_inc, s_busy, s_halted, s_err_ill, s_err_to;
  logic [1:0]  s_count;

  multicycle_control_unit #(
    .OPCODE_W(4), .ALU_OP_W(3), .MEM_TIMEOUT(16), .CNT_W(16)
  ) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Instr_valid(Instr_valid), .Opcode(Opcode),
    .Mem_ready(Mem_ready), .Instr_ready(Instr_ready), .Mem_req(Mem_req),
    .En_write_reg(En_write_reg), .En_write_mem(En_write_mem), .ALU_OP(ALU_OP),
    .Pc_inc(Pc_inc), .Busy(Busy), .Halted(Halted), .Err_illegal(Err_illegal),
    .Err_timeout(Err_timeout), .Instr_count(Instr_count)
  );

  multicycle_control_unit #(
    .OPCODE_W(3), .ALU_OP_W(3), .MEM_TIMEOUT(16), .CNT_W(2)
  ) dut_sat (
    .Clk(Clk), .Reset(Reset), .En(s_en), .Instr_valid(s_valid), .Opcode(s_opcode),
    .Mem_ready(s_mem_ready), .Instr_ready(s_ready), .Mem_req(s_mem_req),
    .En_write_reg(s_wreg), .En_write_mem(s_wmem), .ALU_OP(s_alu_op),
    .Pc_inc(s_pc_inc), .Busy(s_busy), .Halted(s_halted), .Err_illegal(s_err_ill),
    .Err_timeout(s_err_to), .Instr_count(s_count)
  );

  int total = 0;
  int bad   = 0;
  int model_cnt = 0;

  typedef struct {
    int         ret_idx;
    int         memreq;
    int         wmem;
    int         wreg;
    int         illegal;
    logic [2:0] alu2;
    logic [2:0] alu;
    int         count;
  } exp_t;

  exp_t sb[$];
  int   sat_q[$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    Reset = 1'b0; En = 1'b0; Instr_valid = 1'b0; Mem_ready = 1'b0; Opcode = '0;
    s_en = 1'b0; s_valid = 1'b0; s_mem_ready = 1'b0; s_opcode = '0;
    repeat (2) @(posedge Clk);
    #2;
    Reset = 1'b1;
    model_cnt = 0;
  endtask

  // Wait (bounded) for FETCH, present op, cross the handshake edge.
  task automatic handshake(input logic [3:0] op);
    int k;
    Instr_valid = 1'b1; Opcode = op; k = 0;
    while (Instr_ready !== 1'b1 && k < 20) begin tick(); k++; end
    total++;
    if (Instr_ready !== 1'b1) begin
      bad++; $display("FAIL fetch_wait op=%b got Instr_ready=%b want 1", op, Instr_ready);
    end
    tick();
    Instr_valid = 1'b0; Opcode = 4'b1111;
  endtask

  // Run one instruction: expectations go to the scoreboard at issue, and are
  // popped and compared once the retire pulse has been observed.
  task automatic issue(input logic [3:0] op, input int wait_cycles);
    exp_t e, got;
    bit legal, alu, ld, st, done;
    logic [2:0] b;
    int memcyc;
    legal = (op[3] == 1'b0); b = op[2:0];
    alu = legal && (b >= 3'd1) && (b <= 3'd4);
    ld  = legal && (b == 3'd5);
    st  = legal && (b == 3'd6);
    e.ret_idx = alu ? 3 : ld ? 3 + wait_cycles : st ? 2 + wait_cycles : 1;
    e.memreq  = (ld || st) ? wait_cycles + 1 : 0;
    e.wmem    = st ? wait_cycles + 1 : 0;
    e.wreg    = (alu || ld) ? 1 : 0;
    e.illegal = legal ? 0 : 1;
    e.alu2    = alu ? b : 3'd0;
    e.alu     = alu ? b : 3'd0;
    if (model_cnt < 65535) model_cnt++;
    e.count   = model_cnt;
    sb.push_back(e);

    got.ret_idx = 0; got.memreq = 0; got.wmem = 0; got.wreg = 0; got.illegal = 0;
    got.alu2 = 3'd0; got.alu = 3'd0; got.count = 0;
    handshake(op);
    done = 1'b0; memcyc = 0;
    for (int c = 1; c <= 60 && !done; c++) begin
      Mem_ready = (Mem_req === 1'b1) && (memcyc == wait_cycles);
      #1;
      if (c == 2) got.alu2 = ALU_OP;
      if (Mem_req === 1'b1) begin memcyc++; got.memreq++; end
      if (En_write_mem === 1'b1) got.wmem++;
      if (En_write_reg === 1'b1) begin got.wreg++; got.alu = ALU_OP; end
      if (Err_illegal === 1'b1) got.illegal++;
      if (Pc_inc === 1'b1) begin got.ret_idx = c; done = 1'b1; end
      tick();
    end
    Mem_ready = 1'b0;
    got.count = int'(Instr_count);

    e = sb.pop_front();
    total++; if (got.ret_idx != e.ret_idx) begin bad++; $display("FAIL retire_cycle op=%b got %0d want %0d", op, got.ret_idx, e.ret_idx); end
    total++; if (got.memreq != e.memreq) begin bad++; $display("FAIL mem_req_cycles op=%b got %0d want %0d", op, got.memreq, e.memreq); end
    total++; if (got.wmem != e.wmem) begin bad++; $display("FAIL write_mem_cycles op=%b got %0d want %0d", op, got.wmem, e.wmem); end
    total++; if (got.wreg != e.wreg) begin bad++; $display("FAIL write_reg_cycles op=%b got %0d want %0d", op, got.wreg, e.wreg); end
    total++; if (got.illegal != e.illegal) begin bad++; $display("FAIL illegal_pulses op=%b got %0d want %0d", op, got.illegal, e.illegal); end
    total++; if (got.alu2 !== e.alu2) begin bad++; $display("FAIL alu_op_exec op=%b got %b want %b", op, got.alu2, e.alu2); end
    total++; if (got.alu !== e.alu) begin bad++; $display("FAIL alu_op_wb op=%b got %b want %b", op, got.alu, e.alu); end
    total++; if (got.count != e.count) begin bad++; $display("FAIL instr_count op=%b got %0d want %0d", op, got.count, e.count); end
  endtask

  task automatic test_reset();
    apply_reset();
    Reset = 1'b0;
    #1;
    total++; if ({Instr_ready, Mem_req, En_write_reg, En_write_mem, Pc_inc} !== 5'b0) begin bad++; $display("FAIL reset_strobes got %b want 00000", {Instr_ready, Mem_req, En_write_reg, En_write_mem, Pc_inc}); end
    total++; if ({Busy, Halted, Err_illegal, Err_timeout} !== 4'b0) begin bad++; $display("FAIL reset_status got %b want 0000", {Busy, Halted, Err_illegal, Err_timeout}); end
    total++; if (Instr_count !== 16'd0 || ALU_OP !== 3'd0) begin bad++; $display("FAIL reset_count_alu got cnt=%0d alu=%b want 0/000", Instr_count, ALU_OP); end
    Reset = 1'b1;
    tick();
    total++; if (Busy !== 1'b0 || Instr_ready !== 1'b0) begin bad++; $display("FAIL idle_without_en got busy=%b ready=%b want 0/0", Busy, Instr_ready); end
  endtask

  task automatic test_alu();
    En = 1'b1;
    issue(4'b0001, 0);
    issue(4'b0010, 0);
  endtask

  task automatic test_store();
    issue(4'b0110, 3);
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    En = 1'b1;
    handshake(4'b0101);
    n = 0;
    for (int c = 0; c < 40 && Halted !== 1'b1; c++) begin
      if (Mem_req === 1'b1) n++;
      tick();
    end
    total++; if (n != 16) begin bad++; $display("FAIL timeout_mem_cycles got %0d want 16", n); end
    total++; if (Halted !== 1'b1 || Err_timeout !== 1'b1 || Busy !== 1'b0) begin bad++; $display("FAIL timeout_halt got halted=%b err=%b busy=%b want 1/1/0", Halted, Err_timeout, Busy); end
    total++; if (Instr_count !== 16'd0) begin bad++; $display("FAIL timeout_no_retire got %0d want 0", Instr_count); end
    apply_reset();
    total++; if (Err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_cleared got %b want 0", Err_timeout); end
    En = 1'b1;
    issue(4'b0101, 15);
    total++; if (Err_timeout !== 1'b0 || Halted !== 1'b0) begin bad++; $display("FAIL ready_last_cycle got err=%b halted=%b want 0/0", Err_timeout, Halted); end
  endtask

  task automatic test_illegal_halt();
    int pulses;
    issue(4'b1001, 0);
    total++; if (Instr_ready !== 1'b1) begin bad++; $display("FAIL illegal_back_to_fetch got %b want 1", Instr_ready); end
    handshake(4'b0111);
    total++; if (Pc_inc !== 1'b0) begin bad++; $display("FAIL halt_decode_no_retire got %b want 0", Pc_inc); end
    pulses = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      En = c[0]; Instr_valid = 1'b1; Opcode = 4'b0001;
      #1;
      if (Halted !== 1'b1 || Busy !== 1'b0 || Pc_inc !== 1'b0) pulses++;
    end
    Instr_valid = 1'b0;
    total++; if (pulses != 0) begin bad++; $display("FAIL halt_sticky got %0d bad cycles want 0", pulses); end
    total++; if (Instr_count !== 16'(model_cnt)) begin bad++; $display("FAIL halt_count got %0d want %0d", Instr_count, model_cnt); end
    apply_reset();
    total++; if (Halted !== 1'b0) begin bad++; $display("FAIL halt_reset got %b want 0", Halted); end
  endtask

  task automatic test_en_drop_and_abort();
    En = 1'b1;
    handshake(4'b0011);
    tick();
    total++; if (ALU_OP !== 3'b011) begin bad++; $display("FAIL en_drop_exec_alu got %b want 011", ALU_OP); end
    En = 1'b0;
    tick();
    total++; if (En_write_reg !== 1'b1 || Pc_inc !== 1'b1) begin bad++; $display("FAIL en_drop_wb got wreg=%b pc=%b want 1/1", En_write_reg, Pc_inc); end
    model_cnt++;
    tick();
    total++; if (Instr_ready !== 1'b1) begin bad++; $display("FAIL en_drop_fetch got %b want 1", Instr_ready); end
    tick();
    total++; if (Instr_ready !== 1'b0 || Busy !== 1'b0 || Instr_count !== 16'(model_cnt)) begin bad++; $display("FAIL en_drop_idle got ready=%b busy=%b cnt=%0d want 0/0/%0d", Instr_ready, Busy, Instr_count, model_cnt); end
    En = 1'b1;
    handshake(4'b0110);
    tick();
    total++; if (Mem_req !== 1'b1 || En_write_mem !== 1'b1) begin bad++; $display("FAIL abort_in_mem got req=%b wmem=%b want 1/1", Mem_req, En_write_mem); end
    #2;
    Reset = 1'b0;
    #1;
    total++; if ({Instr_ready, Mem_req, En_write_reg, En_write_mem, Pc_inc, Busy, Halted, Err_illegal, Err_timeout} !== 9'b0 || ALU_OP !== 3'd0 || Instr_count !== 16'd0) begin
      bad++; $display("FAIL abort_async got %b alu=%b cnt=%0d want all zero", {Instr_ready, Mem_req, En_write_reg, En_write_mem, Pc_inc, Busy, Halted, Err_illegal, Err_timeout}, ALU_OP, Instr_count);
    end
    apply_reset();
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [8];
    int         waits [8];
    ops = '{4'b0100, 4'b0000, 4'b0101, 4'b0110, 4'b0011, 4'b1100, 4'b0000, 4'b0110};
    waits = '{0, 0, 2, 0, 0, 0, 0, 1};
    En = 1'b1;
    for (int i = 0; i < 8; i++) issue(ops[i], waits[i]);
  endtask

  task automatic test_saturation();
    int retired, got;
    apply_reset();
    s_en = 1'b1; s_valid = 1'b1; s_opcode = 3'b000;
    retired = 0;
    for (int c = 0; c < 60 && retired < 5; c++) begin
      if (s_pc_inc === 1'b1) begin
        retired++;
        sat_q.push_back(retired > 3 ? 3 : retired);
        tick();
        got = int'(s_count);
        total++; if (got != sat_q.pop_front()) begin bad++; $display("FAIL sat_count retire=%0d got %0d", retired, got); end
      end else begin
        tick();
      end
    end
    s_valid = 1'b0;
    total++; if (retired != 5) begin bad++; $display("FAIL sat_retires got %0d want 5", retired); end
    total++; if (s_count !== 2'd3) begin bad++; $display("FAIL sat_final got %0d want 3", s_count); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_back_to_back();
    test_timeout();
    test_illegal_halt();
    test_en_drop_and_abort();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
